// File: rtl/bezier_segment_sequencer.sv
// Steps x across one cubic Bezier segment through a non-stallable 2-stage evaluator,
// using FIFO credits for flow control, and streams absolute position samples.
module bezier_segment_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int EVAL_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic signed [22:0] cmd_a,
  input  logic signed [22:0] cmd_b,
  input  logic signed [22:0] cmd_c,
  input  logic [15:0]        cmd_dx,
  input  logic [15:0]        cmd_n,
  input  logic signed [31:0] cmd_p0,
  output logic [16:0]        ev_x,
  output logic signed [22:0] ev_a,
  output logic signed [22:0] ev_b,
  output logic signed [22:0] ev_c,
  input  logic signed [23:0] ev_out,
  output logic               smp_valid,
  input  logic               smp_ready,
  output logic [31:0]        smp_pos,
  output logic               smp_last,
  output logic               busy,
  output logic               done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(EVAL_LATENCY + 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [22:0]      a_q, a_d, b_q, b_d, c_q, c_d;
  logic [15:0]             dx_q, dx_d, n_q, n_d, k_q, k_d;
  logic [31:0]             p0_q, p0_d;
  logic [16:0]             x_q, x_d;
  logic                    x_vld_q, x_vld_d, x_last_q, x_last_d;
  logic [EVAL_LATENCY-1:0] tag_q, tag_d, tag_last_q, tag_last_d;
  logic [FIFO_DEPTH-1:0][31:0] pos_mem_q, pos_mem_d;
  logic [FIFO_DEPTH-1:0]   last_mem_q, last_mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  logic [IW-1:0] inflight;
  logic [7:0]    credit_used;
  logic [16:0]   x_sum, x_sat;
  logic [15:0]   k_next;
  logic          issue, push, pop;
  logic [31:0]   push_pos;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign ev_x      = x_q;
  assign ev_a      = a_q;
  assign ev_b      = b_q;
  assign ev_c      = c_q;
  assign smp_valid = (count_q != '0);
  assign smp_pos   = pos_mem_q[rd_ptr_q];
  assign smp_last  = smp_valid & last_mem_q[rd_ptr_q];
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    dx_d       = dx_q;
    n_d        = n_q;
    k_d        = k_q;
    p0_d       = p0_q;
    x_d        = x_q;
    pos_mem_d  = pos_mem_q;
    last_mem_d = last_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    issue      = 1'b0;

    // Credits cover every issue not yet retired: the x register stage plus each tag stage.
    inflight = IW'(x_vld_q);
    for (int i = 0; i < EVAL_LATENCY; i++) begin
      inflight = inflight + IW'(tag_q[i]);
    end
    credit_used = 8'(count_q) + 8'(inflight);

    x_sum    = x_q + {1'b0, dx_q};
    x_sat    = (x_sum > 17'd65535) ? 17'd65535 : x_sum;
    k_next   = k_q + 16'd1;
    push     = tag_q[EVAL_LATENCY-1];
    push_pos = p0_q + {{8{ev_out[23]}}, ev_out};
    pop      = smp_valid && smp_ready;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          c_d     = cmd_c;
          dx_d    = cmd_dx;
          n_d     = cmd_n;
          p0_d    = cmd_p0;
          k_d     = '0;
          x_d     = '0;
          state_d = (cmd_n == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if ((k_q < n_q) && (credit_used < 8'(FIFO_DEPTH))) begin
          issue = 1'b1;
          k_d   = k_next;
          x_d   = x_sat;
          if (k_next == n_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && smp_last && (inflight == '0)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    x_vld_d       = issue;
    x_last_d      = issue && (k_next == n_q);
    tag_d[0]      = x_vld_q;
    tag_last_d[0] = x_last_q;
    for (int i = 1; i < EVAL_LATENCY; i++) begin
      tag_d[i]      = tag_q[i-1];
      tag_last_d[i] = tag_last_q[i-1];
    end

    if (push) begin
      pos_mem_d[wr_ptr_q]  = push_pos;
      last_mem_d[wr_ptr_q] = tag_last_q[EVAL_LATENCY-1];
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      dx_q       <= '0;
      n_q        <= '0;
      k_q        <= '0;
      p0_q       <= '0;
      x_q        <= '0;
      x_vld_q    <= 1'b0;
      x_last_q   <= 1'b0;
      tag_q      <= '0;
      tag_last_q <= '0;
      pos_mem_q  <= '0;
      last_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      dx_q       <= dx_d;
      n_q        <= n_d;
      k_q        <= k_d;
      p0_q       <= p0_d;
      x_q        <= x_d;
      x_vld_q    <= x_vld_d;
      x_last_q   <= x_last_d;
      tag_q      <= tag_d;
      tag_last_q <= tag_last_d;
      pos_mem_q  <= pos_mem_d;
      last_mem_q <= last_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // The credit rule must make a push into a full FIFO without a pop unreachable.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

endmodule
